tinyalu_responder: RTL
======================

TINYALU_RESPONDER -- requirements
Module: tinyalu_responder

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port A, input, 8 bits: operand A, unsigned.
REQ-004 The block SHALL have the port B, input, 8 bits: operand B, unsigned.
REQ-005 The block SHALL have the port op, input, 3 bits: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101/110 reserved, 111 clear.
REQ-006 The block SHALL have the port start, input, 1 bit: request, held high by the initiator until done is seen.
REQ-007 The block SHALL have the port done, output, 1 bit: single-cycle completion pulse.
REQ-008 The block SHALL have the port busy, output, 1 bit: high while an operation is in flight (EXEC or DONE state).
REQ-009 The block SHALL have the port result, output, 16 bits: result of the last completed operation.

Function
REQ-010 The block SHALL implement the states IDLE, EXEC and DONE.
REQ-011 In IDLE, a rising edge with start=1 SHALL be the capture edge: A, B and op are latched, and later input changes have no effect on the operation.
REQ-012 Add, and, and xor SHALL go IDLE->DONE at the capture edge, so done=1 in the cycle immediately after the capture edge (latency 1).
REQ-013 Mul SHALL go IDLE->EXEC at the capture edge and EXEC->DONE when the multiply completes.
REQ-014 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-015 The start input SHALL be ignored while in EXEC and DONE.
REQ-016 result SHALL update on the same edge that enters DONE and SHALL hold until the next operation completes or a clear occurs.
REQ-017 Add SHALL produce the 9-bit sum, zero-extended to 16 bits; 0xFF+0xFF=0x01FE.
REQ-018 And and xor SHALL produce 8-bit results, zero-extended to 16 bits.
REQ-019 Mul SHALL produce the full 16-bit unsigned product; 0xFF*0xFF=0xFE01.
REQ-020 No_op (000) and reserved codes (101, 110) SHALL be accepted in IDLE with no state change, no done, and result unchanged.
REQ-021 Clear (111) SHALL set result to 0x0000 at the capture edge, stay in IDLE, and not assert done.
REQ-022 If start drops during EXEC, the operation SHALL still complete and pulse done.
REQ-023 If start is still high in the cycle after DONE, IDLE SHALL treat it as a new capture edge, which makes back-to-back operations legal.
REQ-024 Reset asserted mid-operation SHALL abort the operation; no done pulse follows.

Reset
REQ-025 While reset=1 at a rising edge, the block SHALL go to IDLE with done=0, busy=0, result=0x0000, and all internal operand, product and counter registers cleared.
REQ-026 Reset SHALL take priority over start and over any pending completion on the same edge.

Configuration
REQ-027 The macro TINYALU_ITER_MUL_EN SHALL select the multiplier implementation.
REQ-028 When TINYALU_ITER_MUL_EN is undefined, mul SHALL be a 2-stage registered multiply in EXEC, giving done=1 in the third cycle after the capture edge (latency 3).
REQ-029 When TINYALU_ITER_MUL_EN is defined, mul SHALL be a shift-add over 8 EXEC cycles using a 4-bit counter, giving done=1 in the ninth cycle after the capture edge (latency 9).
REQ-030 Both multiplier builds SHALL give bit-identical results, and all other operations SHALL be unaffected by the macro.

Verification
REQ-031 Add test: reset 2 cycles, then start with op=001, A=0xFF, B=0xFF -> done pulses one cycle later; result=0x01FE; busy=1 only in the DONE cycle.
REQ-032 Mul test: op=100, A=0xFF, B=0xFF, start held until done -> result=0xFE01; done at latency 3 (macro undefined) or 9 (macro defined); A/B changes after capture ignored.
REQ-033 And/xor test: op=010 with A=0xF0, B=0x3C -> result=0x0030; then op=011 with the same operands -> result=0x00CC; the second start is held through the DONE cycle, so the back-to-back capture works.
REQ-034 No_op and clear test: op=000 for one cycle -> no done, result unchanged; op=111 -> result=0x0000, no done.
REQ-035 Reset abort test: reset=1 two cycles after a mul capture -> done never pulses; result=0x0000; the next add of 0x01+0x02 -> result=0x0003.
REQ-036 Early-drop test: start drops the cycle after a mul capture -> done still pulses at the specified latency with the correct product.

Source files
------------

// File: rtl/tinyalu_responder.sv
// TinyALU responder: start/done handshake ALU with IDLE/EXEC/DONE control.
// Define TINYALU_ITER_MUL_EN for an 8-step shift-add multiplier; default is a 2-stage registered multiply.
module tinyalu_responder (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   input  logic [2:0]  op,
   input  logic        start,
   output logic        done,
   output logic        busy,
   output logic [15:0] result
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   typedef enum logic [2:0] {
      OP_NOP = 3'b000, OP_ADD = 3'b001, OP_AND = 3'b010,
      OP_XOR = 3'b011, OP_MUL = 3'b100, OP_CLR = 3'b111
   } op_t;

   state_t      state;
   logic [7:0]  a_q, b_q;
   logic [15:0] prod;
   logic [15:0] alu_out;

`ifdef TINYALU_ITER_MUL_EN
   logic [3:0]  cnt;
   logic [15:0] acc_next;

   // One partial product per EXEC cycle, LSB of B first.
   always_comb begin
      acc_next = prod;
      if (b_q[cnt[2:0]])
         acc_next = prod + ({8'h00, a_q} << cnt[2:0]);
   end
`else
   logic        stage;
`endif

   always_comb begin
      alu_out = '0;
      case (op)
         OP_ADD:  alu_out = {7'b0, {1'b0, A} + {1'b0, B}};
         OP_AND:  alu_out = {8'h00, A & B};
         OP_XOR:  alu_out = {8'h00, A ^ B};
         default: alu_out = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         done   <= 1'b0;
         busy   <= 1'b0;
         result <= '0;
         a_q    <= '0;
         b_q    <= '0;
         prod   <= '0;
`ifdef TINYALU_ITER_MUL_EN
         cnt    <= '0;
`else
         stage  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  case (op)
                     OP_ADD, OP_AND, OP_XOR: begin
                        result <= alu_out;
                        state  <= DONE;
                        done   <= 1'b1;
                        busy   <= 1'b1;
                     end
                     OP_MUL: begin
                        a_q   <= A;
                        b_q   <= B;
                        prod  <= '0;
`ifdef TINYALU_ITER_MUL_EN
                        cnt   <= '0;
`else
                        stage <= 1'b0;
`endif
                        state <= EXEC;
                        busy  <= 1'b1;
                     end
                     OP_CLR:  result <= '0;
                     default: ;
                  endcase
               end
            end
            EXEC: begin
`ifdef TINYALU_ITER_MUL_EN
               prod <= acc_next;
               if (cnt == 4'd7) begin
                  result <= acc_next;
                  state  <= DONE;
                  done   <= 1'b1;
               end else begin
                  cnt <= cnt + 4'd1;
               end
`else
               if (!stage) begin
                  prod  <= 16'(a_q) * 16'(b_q);
                  stage <= 1'b1;
               end else begin
                  result <= prod;
                  state  <= DONE;
                  done   <= 1'b1;
               end
`endif
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
